// File: rtl/cpu_0_jtag_ocimem_ctrl_if.sv
// Debug-memory sequencer bundle: command side from the debug module's sysclk
// stage, monitor results back to the tck stage, and the debug-RAM request port.
interface cpu_0_jtag_ocimem_ctrl_if #(
  parameter int unsigned ADDR_W = 8
);
  // Command payload and strobes
  logic [37:0]       jdo;
  logic              take_action_ocimem_a;
  logic              take_no_action_ocimem_a;
  logic              take_action_ocimem_b;
  // Monitor results
  logic [31:0]       MonDReg;
  logic              monitor_ready;
  logic              monitor_error;
  logic              cmd_overrun;
  logic              busy;
  // Debug-RAM request port
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic              mem_waitrequest;
  logic [31:0]       mem_readdata;
  logic              mem_readdatavalid;

  // Sequencer view
  modport master (
    input  jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
    input  mem_waitrequest, mem_readdata, mem_readdatavalid,
    output MonDReg, monitor_ready, monitor_error, cmd_overrun, busy,
    output mem_address, mem_read, mem_write, mem_writedata
  );

  // Environment view: debug module plus RAM slave
  modport slave (
    output jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
    output mem_waitrequest, mem_readdata, mem_readdatavalid,
    input  MonDReg, monitor_ready, monitor_error, cmd_overrun, busy,
    input  mem_address, mem_read, mem_write, mem_writedata
  );
endinterface

// File: rtl/cpu_0_jtag_ocimem_ctrl.sv
// Debug-memory access sequencer: turns JTAG debug strobes into single reads or
// writes on the debug-RAM port and reports data/status back to the debug module.
// The monitor address auto-increments after every completed access.
module cpu_0_jtag_ocimem_ctrl #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input logic                     clk,
  input logic                     reset,
  cpu_0_jtag_ocimem_ctrl_if.master bus
);

  typedef enum logic [1:0] {StIdle, StRdReq, StRdWait, StWrReq} state_e;

  localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] mon_a_q;
  logic [31:0]       mon_d_q;
  logic              ready_q;
  logic              error_q;
  logic              overrun_q;
  logic              busy_q;
  logic              rd_q;
  logic              wr_q;
  logic [31:0]       wdata_q;
  logic [15:0]       tmo_q;

  logic any_strobe;
  logic rd_done;
  logic tmo_hit;

  assign any_strobe = bus.take_action_ocimem_a | bus.take_action_ocimem_b |
                      bus.take_no_action_ocimem_a;
  assign tmo_hit    = (tmo_q == TmoLast);

  // Read completes when data is qualified; in RD_REQ only together with acceptance.
  always_comb begin
    rd_done = 1'b0;
    case (state_q)
      StRdReq:  rd_done = !bus.mem_waitrequest && bus.mem_readdatavalid;
      StRdWait: rd_done = bus.mem_readdatavalid;
      default:  rd_done = 1'b0;
    endcase
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      mon_a_q   <= '0;
      mon_d_q   <= '0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      tmo_q     <= '0;
    end else begin
      // Strobes only land in IDLE; anything else is dropped and flagged.
      if (state_q != StIdle && any_strobe) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (bus.take_action_ocimem_a) begin
            mon_a_q <= bus.jdo[ADDR_W+25:26];
            if (bus.jdo[34]) begin
              error_q <= 1'b0;
            end
            // Address-only command completes on the accepting edge.
            ready_q <= ~bus.jdo[35];
            if (bus.jdo[35]) begin
              state_q <= StRdReq;
              rd_q    <= 1'b1;
              busy_q  <= 1'b1;
              tmo_q   <= '0;
            end
          end else if (bus.take_action_ocimem_b) begin
            wdata_q <= bus.jdo[34:3];
            ready_q <= 1'b0;
            state_q <= StWrReq;
            wr_q    <= 1'b1;
            busy_q  <= 1'b1;
          end else if (bus.take_no_action_ocimem_a) begin
            ready_q <= 1'b0;
            state_q <= StRdReq;
            rd_q    <= 1'b1;
            busy_q  <= 1'b1;
            tmo_q   <= '0;
          end
        end
        StRdReq, StRdWait: begin
          if (rd_done) begin
            mon_d_q <= bus.mem_readdata;
            mon_a_q <= mon_a_q + 1'b1;
            ready_q <= 1'b1;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else if (tmo_hit) begin
            // Give up: data and address stay as they were.
            error_q <= 1'b1;
            ready_q <= 1'b1;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            tmo_q <= tmo_q + 16'd1;
            if (state_q == StRdReq && !bus.mem_waitrequest) begin
              rd_q    <= 1'b0;
              state_q <= StRdWait;
            end
          end
        end
        StWrReq: begin
          if (!bus.mem_waitrequest) begin
            wr_q    <= 1'b0;
            mon_a_q <= mon_a_q + 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.MonDReg       = mon_d_q;
  assign bus.monitor_ready = ready_q;
  assign bus.monitor_error = error_q;
  assign bus.cmd_overrun   = overrun_q;
  assign bus.busy          = busy_q;
  assign bus.mem_address   = mon_a_q;
  assign bus.mem_read      = rd_q;
  assign bus.mem_write     = wr_q;
  assign bus.mem_writedata = wdata_q;

endmodule

// File: tb/tb_cpu_0_jtag_ocimem_ctrl.sv
// Bench for the debug-memory sequencer: directed scenarios plus random commands,
// an emulated RAM slave, and two monitors fed by expectation queues.
module tb_cpu_0_jtag_ocimem_ctrl;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cpu_0_jtag_ocimem_ctrl_if #(.ADDR_W(8)) dif ();

  cpu_0_jtag_ocimem_ctrl #(.ADDR_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif)
  );

  typedef struct { bit wr; logic [7:0] addr; logic [31:0] data; } beat_t;
  typedef struct { logic [31:0] dreg; bit err; logic [7:0] addr; bit ovr; } resp_t;

  beat_t beat_q[$];
  resp_t resp_q[$];

  int checks = 0;
  int failures = 0;

  // Reference state
  logic [7:0]  m_addr = '0;
  logic [31:0] m_dreg = '0;
  bit          m_err = 1'b0;
  bit          m_ovr = 1'b0;
  logic [31:0] ref_mem [256];
  logic [31:0] slv_mem [256];

  // Slave behaviour for the current command
  int cfg_w = 0;
  int cfg_l = 0;
  bit cfg_novalid = 1'b0;
  bit stray_req = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read outcome: accepted if the slave lowers waitrequest before the limit,
  // completes if the data arrives no later than cycle TIMEOUT-1 of the read.
  task automatic model_read(input int w, input int l, input bit nv);
    beat_t b;
    if (w <= TIMEOUT - 1) begin
      b = '{wr: 1'b0, addr: m_addr, data: 32'h0};
      beat_q.push_back(b);
    end
    if (!nv && (w + l <= TIMEOUT - 1)) begin
      m_dreg = ref_mem[m_addr];
      m_addr = m_addr + 8'd1;
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic issue(input bit a, input bit b, input bit na, input logic [37:0] jdo,
                       input int w, input int l, input bit nv, input bit will_ovr);
    beat_t bt;
    resp_t r;
    cfg_w = w;
    cfg_l = l;
    cfg_novalid = nv;
    if (a) begin
      m_addr = jdo[33:26];
      if (jdo[34]) m_err = 1'b0;
      if (jdo[35]) model_read(w, l, nv);
    end else if (b) begin
      bt = '{wr: 1'b1, addr: m_addr, data: jdo[34:3]};
      beat_q.push_back(bt);
      ref_mem[m_addr] = jdo[34:3];
      m_addr = m_addr + 8'd1;
    end else if (na) begin
      model_read(w, l, nv);
    end
    if (will_ovr) m_ovr = 1'b1;
    r = '{dreg: m_dreg, err: m_err, addr: m_addr, ovr: m_ovr};
    resp_q.push_back(r);
    dif.jdo = jdo;
    dif.take_action_ocimem_a = a;
    dif.take_action_ocimem_b = b;
    dif.take_no_action_ocimem_a = na;
    tick();
    dif.take_action_ocimem_a = 1'b0;
    dif.take_action_ocimem_b = 1'b0;
    dif.take_no_action_ocimem_a = 1'b0;
    dif.jdo = {$urandom, $urandom};
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!(dif.busy == 1'b0 && dif.monitor_ready == 1'b1) && n < 300) begin
      tick();
      n++;
    end
    chk({name, "_done_in_time"}, 64'(n < 300), 64'd1);
  endtask

  task automatic gap();
    repeat (6) tick();
  endtask

  function automatic logic [37:0] jdo_a(input bit rd, input bit clr, input logic [7:0] addr);
    logic [37:0] j;
    j = {$urandom, $urandom};
    j[35] = rd;
    j[34] = clr;
    j[33:26] = addr;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] data);
    logic [37:0] j;
    j = {$urandom, $urandom};
    j[34:3] = data;
    return j;
  endfunction

  // RAM slave: waitrequest for the first cfg_w request cycles, data cfg_l cycles later.
  initial begin
    int req_cyc = 0;
    bit rv_pend = 1'b0;
    int rv_cnt = 0;
    logic [31:0] rv_data = '0;
    dif.mem_waitrequest = 1'b0;
    dif.mem_readdatavalid = 1'b0;
    dif.mem_readdata = '0;
    forever begin
      tick();
      dif.mem_readdatavalid = 1'b0;
      dif.mem_readdata = $urandom;
      if (reset) begin
        req_cyc = 0;
        rv_pend = 1'b0;
        dif.mem_waitrequest = 1'b0;
      end else begin
        if (rv_pend) begin
          rv_cnt--;
          if (rv_cnt == 0) begin
            rv_pend = 1'b0;
            dif.mem_readdatavalid = 1'b1;
            dif.mem_readdata = rv_data;
          end
        end
        if (stray_req) begin
          stray_req = 1'b0;
          dif.mem_readdatavalid = 1'b1;
          dif.mem_readdata = 32'hDEADBEEF;
        end
        if (dif.mem_read || dif.mem_write) begin
          dif.mem_waitrequest = (req_cyc < cfg_w);
          if (!dif.mem_waitrequest) begin
            if (dif.mem_write) begin
              slv_mem[dif.mem_address] = dif.mem_writedata;
            end else if (!cfg_novalid) begin
              if (cfg_l == 0) begin
                dif.mem_readdatavalid = 1'b1;
                dif.mem_readdata = slv_mem[dif.mem_address];
              end else begin
                rv_pend = 1'b1;
                rv_cnt = cfg_l;
                rv_data = slv_mem[dif.mem_address];
              end
            end
          end
          req_cyc++;
        end else begin
          req_cyc = 0;
          dif.mem_waitrequest = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Bus monitor: every accepted request beat must match the next expected one.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (!reset && (dif.mem_read || dif.mem_write) && !dif.mem_waitrequest) begin
        if (beat_q.size() == 0) begin
          chk("unexpected_beat", 64'd1, 64'd0);
        end else begin
          b = beat_q.pop_front();
          chk("beat_is_write", 64'(dif.mem_write), 64'(b.wr));
          chk("beat_addr", 64'(dif.mem_address), 64'(b.addr));
          if (b.wr) chk("beat_wdata", 64'(dif.mem_writedata), 64'(b.data));
        end
      end
    end
  end

  // Completion monitor: an accepted command ends when the block is idle and ready.
  initial begin
    bit armed = 1'b0;
    int age = 0;
    resp_t r;
    forever begin
      @(negedge clk);
      if (reset) begin
        armed = 1'b0;
      end else begin
        if (armed) begin
          if (!dif.busy && dif.monitor_ready) begin
            armed = 1'b0;
            if (resp_q.size() == 0) begin
              chk("unexpected_completion", 64'd1, 64'd0);
            end else begin
              r = resp_q.pop_front();
              chk("resp_MonDReg", 64'(dif.MonDReg), 64'(r.dreg));
              chk("resp_error", 64'(dif.monitor_error), 64'(r.err));
              chk("resp_address", 64'(dif.mem_address), 64'(r.addr));
              chk("resp_overrun", 64'(dif.cmd_overrun), 64'(r.ovr));
            end
          end else begin
            age++;
            if (age > 300) begin
              armed = 1'b0;
              chk("completion_seen", 64'd0, 64'd1);
              if (resp_q.size() != 0) r = resp_q.pop_front();
            end
          end
        end
        if ((dif.take_action_ocimem_a || dif.take_action_ocimem_b ||
             dif.take_no_action_ocimem_a) && !dif.busy) begin
          armed = 1'b1;
          age = 0;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    int n;
    bit a, b, na, nv;
    int w, l;
    logic [2:0] mask;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = $urandom;
      slv_mem[i] = ref_mem[i];
    end
    ref_mem[8'h10] = 32'hCAFE0001;
    slv_mem[8'h10] = 32'hCAFE0001;
    dif.jdo = '0;
    dif.take_action_ocimem_a = 1'b0;
    dif.take_action_ocimem_b = 1'b0;
    dif.take_no_action_ocimem_a = 1'b0;
    repeat (3) tick();
    chk("rst_MonDReg", 64'(dif.MonDReg), 64'd0);
    chk("rst_flags", 64'({dif.monitor_ready, dif.monitor_error, dif.cmd_overrun, dif.busy}),
        64'd0);
    chk("rst_req", 64'({dif.mem_read, dif.mem_write}), 64'd0);
    chk("rst_addr_wdata", 64'({dif.mem_address, dif.mem_writedata}), 64'd0);
    reset = 1'b0;
    tick();

    // Load 0x10 and read it; data one cycle after zero-wait acceptance.
    issue(1, 0, 0, jdo_a(1'b1, 1'b0, 8'h10), 0, 1, 0, 0);
    chk("lat_read_high", 64'(dif.mem_read), 64'd1);
    chk("lat_read_addr", 64'(dif.mem_address), 64'h10);
    tick();
    chk("lat_ready_low_n2", 64'(dif.monitor_ready), 64'd0);
    tick();
    chk("lat_ready_n3", 64'(dif.monitor_ready), 64'd1);
    chk("lat_MonDReg_n3", 64'(dif.MonDReg), 64'hCAFE0001);
    chk("lat_addr_n3", 64'(dif.mem_address), 64'h11);
    wait_done("read10");
    gap();

    // Write at 0xFF with three stall cycles; address wraps.
    issue(1, 0, 0, jdo_a(1'b0, 1'b0, 8'hFF), 0, 0, 0, 0);
    gap();
    issue(0, 1, 0, jdo_b(32'h12345678), 3, 0, 0, 0);
    n = 0;
    while (dif.mem_write && n < 50) begin
      n++;
      tick();
    end
    chk("write_held_cycles", 64'(n), 64'd4);
    wait_done("writeFF");
    chk("write_wrap_addr", 64'(dif.mem_address), 64'h00);
    gap();

    // Read with no data: error exactly TIMEOUT cycles after mem_read rises.
    issue(1, 0, 0, jdo_a(1'b1, 1'b0, 8'h20), 0, 0, 1, 0);
    n = 0;
    while (!dif.monitor_error && n < 200) begin
      tick();
      n++;
    end
    chk("timeout_cycles", 64'(n), 64'(TIMEOUT));
    chk("timeout_read_low", 64'(dif.mem_read), 64'd0);
    chk("timeout_ready", 64'(dif.monitor_ready), 64'd1);
    wait_done("timeout");
    stray_req = 1'b1;
    repeat (4) tick();
    chk("stray_MonDReg", 64'(dif.MonDReg), 64'hCAFE0001);
    chk("stray_addr", 64'(dif.mem_address), 64'h20);
    chk("stray_state", 64'({dif.busy, dif.monitor_ready, dif.monitor_error}), 64'b011);
    issue(1, 0, 0, jdo_a(1'b0, 1'b1, 8'h30), 0, 0, 0, 0);
    wait_done("clear_err");
    chk("error_cleared", 64'(dif.monitor_error), 64'd0);
    gap();

    // Simultaneous action_a and action_b: address load wins, no write.
    issue(1, 1, 0, jdo_a(1'b0, 1'b0, 8'h55), 0, 0, 0, 0);
    chk("prio_ready", 64'(dif.monitor_ready), 64'd1);
    chk("prio_no_write", 64'(dif.mem_write), 64'd0);
    chk("prio_no_overrun", 64'(dif.cmd_overrun), 64'd0);
    chk("prio_addr", 64'(dif.mem_address), 64'h55);
    gap();

    // Read/timeout boundary: data on the last allowed cycle, then one cycle late.
    issue(0, 0, 1, 38'h0, 60, 3, 0, 0);
    wait_done("edge_ok");
    gap();
    issue(0, 0, 1, 38'h0, 61, 3, 0, 0);
    wait_done("edge_late");
    gap();
    issue(1, 0, 0, jdo_a(1'b0, 1'b1, 8'h60), 0, 0, 0, 0);
    gap();

    // Strobe while in RD_WAIT: dropped, flagged, read still completes.
    issue(0, 0, 1, 38'h0, 0, 5, 0, 1);
    tick();
    dif.take_no_action_ocimem_a = 1'b1;
    tick();
    dif.take_no_action_ocimem_a = 1'b0;
    chk("overrun_set", 64'(dif.cmd_overrun), 64'd1);
    wait_done("overrun_read");
    gap();
    chk("overrun_sticky", 64'(dif.cmd_overrun), 64'd1);

    // Random commands, strobe combinations and slave timing.
    for (int k = 0; k < 120; k++) begin
      mask = 3'($urandom_range(1, 7));
      a = mask[0];
      b = mask[1];
      na = mask[2];
      w = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 70) : $urandom_range(0, 3);
      l = $urandom_range(0, 4);
      nv = ($urandom_range(0, 19) == 0);
      issue(a, b, na, {$urandom, $urandom}, w, l, nv, 0);
      wait_done("rand");
      gap();
    end

    repeat (4) tick();
    chk("beats_all_seen", 64'(beat_q.size()), 64'd0);
    chk("resps_all_seen", 64'(resp_q.size()), 64'd0);

    // Reset while a write is stalled.
    cfg_w = 1000;
    dif.jdo = jdo_b(32'hA5A5A5A5);
    dif.take_action_ocimem_b = 1'b1;
    tick();
    dif.take_action_ocimem_b = 1'b0;
    repeat (3) tick();
    chk("stalled_write_active", 64'(dif.mem_write), 64'd1);
    reset = 1'b1;
    tick();
    chk("rst_mid_write", 64'({dif.mem_write, dif.mem_read, dif.busy}), 64'd0);
    chk("rst_mid_flags", 64'({dif.monitor_ready, dif.monitor_error, dif.cmd_overrun}),
        64'd0);
    chk("rst_mid_data", 64'({dif.MonDReg, dif.mem_writedata}), 64'd0);
    chk("rst_mid_addr", 64'(dif.mem_address), 64'd0);
    reset = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
